id_ex_stage_reg: RTL and testbench

//   ID/EX pipeline register of the 32-bit MIPS pipeline; sits directly downstream of the decode control unit.

---
 rtl/id_ex_stage_reg.sv | 114 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: latches decoded control and operands, inserts a bubble on
// load-use hazards, honours flush and external hold, and counts inserted bubbles.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic [1:0]        id_wb,
    input  logic [2:0]        id_m,
    input  logic [3:0]        id_ex,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    output logic [1:0]        ex_wb,
    output logic [2:0]        ex_m,
    output logic [3:0]        ex_ex,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [1:0]        r_wb;
    logic [2:0]        r_m;
    logic [3:0]        r_ex;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic w_haz;
    logic w_kill;

    // A load in EX (MemRead = ex_m[1]) whose rt feeds the instruction in ID; $zero never counts.
    assign w_haz  = r_valid & r_m[1] & (r_rt != '0) & ((r_rt == id_rs) | (r_rt == id_rt));
    assign w_kill = flush | w_haz;
    assign stall  = w_haz & ~hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb    <= '0;
            r_m     <= '0;
            r_ex    <= '0;
            r_pc4   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (!hold) begin
            r_pc4 <= id_pc4;
            r_rd1 <= id_rd1;
            r_rd2 <= id_rd2;
            r_imm <= id_imm;
            r_rs  <= id_rs;
            r_rt  <= id_rt;
            r_rd  <= id_rd;
            if (w_kill) begin
                r_wb    <= '0;
                r_m     <= '0;
                r_ex    <= '0;
                r_valid <= 1'b0;
            end else begin
                r_wb    <= id_wb;
                r_m     <= id_m;
                r_ex    <= id_ex;
                r_valid <= 1'b1;
            end
            // Flush takes priority and squashes without counting as a bubble.
            if (!flush && w_haz && (r_cnt != CntMax)) begin
                r_cnt <= r_cnt + CntOne;
            end
        end
    end

    assign ex_wb      = r_wb;
    assign ex_m       = r_m;
    assign ex_ex      = r_ex;
    assign ex_pc4     = r_pc4;
    assign ex_rd1     = r_rd1;
    assign ex_rd2     = r_rd2;
    assign ex_imm     = r_imm;
    assign ex_rs      = r_rs;
    assign ex_rt      = r_rt;
    assign ex_rd      = r_rd;
    assign ex_valid   = r_valid;
    assign bubble_cnt = r_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vector table, load-use/flush/hold/reset sequences,
// and randomized traffic checked against an instruction-slot model.
module tb_id_ex_stage_reg;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hold = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    id_wb = '0;
    logic [2:0]    id_m = '0;
    logic [3:0]    id_ex = '0;
    logic [DW-1:0] id_pc4 = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;

    logic [1:0]    ex_wb, s_wb;
    logic [2:0]    ex_m, s_m;
    logic [3:0]    ex_ex, s_ex;
    logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm, s_pc4, s_rd1, s_rd2, s_imm;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd, s_rs, s_rt, s_rd;
    logic          ex_valid, stall, s_valid, s_stall;
    logic [15:0]   bubble_cnt;
    logic [1:0]    s_cnt;

    id_ex_stage_reg u_dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_pc4(id_pc4),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_wb(ex_wb), .ex_m(ex_m), .ex_ex(ex_ex), .ex_pc4(ex_pc4),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    // Same stimulus, 2-bit counter to exercise saturation.
    id_ex_stage_reg #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_pc4(id_pc4),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_wb(s_wb), .ex_m(s_m), .ex_ex(s_ex), .ex_pc4(s_pc4),
        .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .ex_valid(s_valid), .stall(s_stall), .bubble_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    // Model: the instruction occupying EX, plus an unbounded count of bubbles.
    typedef struct packed {
        logic          valid;
        logic [1:0]    wb;
        logic [2:0]    m;
        logic [3:0]    ex;
        logic [DW-1:0] pc4, rd1, rd2, imm;
        logic [RW-1:0] rs, rt, rd;
    } slot_t;

    slot_t       slot;
    int unsigned n_bubbles;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        bit         h;
        bit         f;
        logic [1:0] wb;
        logic [2:0] m;
        logic [3:0] ex;
        logic [4:0] rs;
        logic [4:0] rt;
        bit         exp_stall;
        bit         exp_valid;
        logic [2:0] exp_m;
        int         exp_cnt;
    } vec_t;

    localparam logic [1:0] WbR = 2'b10, WbLw = 2'b11, WbBr = 2'b00;
    localparam logic [2:0] MR = 3'b000, MLw = 3'b010, MBr = 3'b100;
    localparam logic [3:0] ExR = 4'b1100, ExLw = 4'b0001, ExBr = 4'b0010;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit load_use();
        return slot.valid && slot.m[1] && (slot.rt != 0) && (slot.rt == id_rs || slot.rt == id_rt);
    endfunction

    function automatic int unsigned sat(input int unsigned n, input int unsigned max);
        return (n > max) ? max : n;
    endfunction

    task automatic model_reset();
        slot      = '0;
        n_bubbles = 0;
    endtask

    task automatic model_edge();
        slot_t nxt;
        bit    lu;
        if (hold) return;
        lu = load_use();
        nxt = '{valid: 1'b1, wb: id_wb, m: id_m, ex: id_ex, pc4: id_pc4, rd1: id_rd1,
                rd2: id_rd2, imm: id_imm, rs: id_rs, rt: id_rt, rd: id_rd};
        if (flush || lu) begin
            nxt.valid = 1'b0;
            nxt.wb    = '0;
            nxt.m     = '0;
            nxt.ex    = '0;
        end
        if (!flush && lu) n_bubbles++;
        slot = nxt;
    endtask

    task automatic chk_outputs();
        chk("ctrl", 64'({ex_valid, ex_wb, ex_m, ex_ex}), 64'({slot.valid, slot.wb, slot.m, slot.ex}));
        chk("pc4", 64'(ex_pc4), 64'(slot.pc4));
        chk("rd1_rd2", {ex_rd1, ex_rd2}, {slot.rd1, slot.rd2});
        chk("imm", 64'(ex_imm), 64'(slot.imm));
        chk("regs", 64'({ex_rs, ex_rt, ex_rd}), 64'({slot.rs, slot.rt, slot.rd}));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(sat(n_bubbles, 65535)));
        chk("sat_ctrl", 64'({s_valid, s_wb, s_m, s_ex}), 64'({slot.valid, slot.wb, slot.m, slot.ex}));
        chk("sat_cnt", 64'(s_cnt), 64'(sat(n_bubbles, 3)));
    endtask

    // Called at posedge+1; drives inputs, checks stall mid-cycle, then checks registers.
    task automatic step(input bit h, input bit f, input logic [1:0] wb, input logic [2:0] m,
                        input logic [3:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                        output bit obs_stall);
        hold   = h;
        flush  = f;
        id_wb  = wb;
        id_m   = m;
        id_ex  = ex;
        id_rs  = rs;
        id_rt  = rt;
        id_rd  = 5'($urandom);
        id_pc4 = $urandom;
        id_rd1 = $urandom;
        id_rd2 = $urandom;
        id_imm = $urandom;
        #2;
        obs_stall = stall;
        chk("stall", 64'(stall), 64'(!h && load_use()));
        chk("sat_stall", 64'(s_stall), 64'(!h && load_use()));
        @(posedge clk);
        model_edge();
        #1;
        chk_outputs();
    endtask

    vec_t vecs[$];
    bit   st;

    initial begin
        // Reset with random ID inputs: every output must read zero.
        model_reset();
        id_wb  = 2'($urandom);
        id_m   = 3'($urandom);
        id_ex  = 4'($urandom);
        id_pc4 = $urandom;
        id_rd1 = $urandom;
        id_rs  = 5'($urandom);
        id_rt  = 5'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk_outputs();
        chk("reset_stall", 64'(stall), 64'(0));
        rst_n = 1'b1;

        vecs = '{
            '{0, 0, WbR,  MR,  ExR,  5'd1,  5'd2,  0, 1, MR,  0},  // R-type
            '{0, 0, WbLw, MLw, ExLw, 5'd3,  5'd8,  0, 1, MLw, 0},  // lw rt=8
            '{0, 0, WbR,  MR,  ExR,  5'd8,  5'd9,  1, 0, MR,  1},  // add rs=8: bubble
            '{0, 0, WbR,  MR,  ExR,  5'd8,  5'd9,  0, 1, MR,  1},  // add reissued
            '{0, 0, WbLw, MLw, ExLw, 5'd4,  5'd0,  0, 1, MLw, 1},  // lw rt=0
            '{0, 0, WbR,  MR,  ExR,  5'd0,  5'd0,  0, 1, MR,  1},  // $zero: no stall
            '{0, 1, WbBr, MBr, ExBr, 5'd5,  5'd6,  0, 0, MR,  1},  // flushed beq
            '{0, 0, WbLw, MLw, ExLw, 5'd1,  5'd10, 0, 1, MLw, 1},  // lw rt=10
            '{1, 0, WbR,  MR,  ExR,  5'd10, 5'd3,  0, 1, MLw, 1},  // held hazard
            '{1, 0, WbR,  MR,  ExR,  5'd10, 5'd3,  0, 1, MLw, 1},
            '{1, 0, WbR,  MR,  ExR,  5'd10, 5'd3,  0, 1, MLw, 1},
            '{0, 0, WbR,  MR,  ExR,  5'd10, 5'd3,  1, 0, MR,  2},  // hold released
            '{0, 0, WbR,  MR,  ExR,  5'd10, 5'd3,  0, 1, MR,  2},
            '{0, 0, WbLw, MLw, ExLw, 5'd2,  5'd7,  0, 1, MLw, 2},  // lw rt=7
            '{0, 1, WbR,  MR,  ExR,  5'd7,  5'd1,  1, 0, MR,  2}   // flush over hazard
        };
        foreach (vecs[i]) begin
            step(vecs[i].h, vecs[i].f, vecs[i].wb, vecs[i].m, vecs[i].ex,
                 vecs[i].rs, vecs[i].rt, st);
            chk($sformatf("tbl%0d_stall", i), 64'(st), 64'(vecs[i].exp_stall));
            chk($sformatf("tbl%0d_valid", i), 64'(ex_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("tbl%0d_m", i), 64'(ex_m), 64'(vecs[i].exp_m));
            chk($sformatf("tbl%0d_cnt", i), 64'(bubble_cnt), 64'(vecs[i].exp_cnt));
        end

        // Five back-to-back load-use pairs: 2-bit counter pins at 3.
        for (int k = 0; k < 5; k++) begin
            step(0, 0, WbLw, MLw, ExLw, 5'd1, 5'd11, st);
            step(0, 0, WbR, MR, ExR, 5'd11, 5'd2, st);
            chk("pair_stall", 64'(st), 64'(1));
        end
        chk("cnt_after_pairs", 64'(bubble_cnt), 64'(7));
        chk("sat_cnt_pinned", 64'(s_cnt), 64'(3));

        // Randomized traffic with small register indices to provoke dependencies.
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 8) == 0, ($urandom % 8) == 0, 2'($urandom), 3'($urandom),
                 4'($urandom), 5'($urandom % 4), 5'($urandom % 4), st);
        end

        // Asynchronous reset in the middle of a stall cycle.
        step(0, 0, WbLw, MLw, ExLw, 5'd1, 5'd5, st);
        id_wb = WbR;
        id_m  = MR;
        id_ex = ExR;
        id_rs = 5'd5;
        id_rt = 5'd2;
        #2;
        chk("pre_reset_stall", 64'(stall), 64'(1));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_outputs();
        chk("async_reset_stall", 64'(stall), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, WbR, MR, ExR, 5'd5, 5'd2, st);
        chk("post_reset_no_haz", 64'(st), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
